// File: rtl/alu_rs_scheduler_pkg.sv
// Shared constants for the ALU reservation station: RoB tag width, default depth,
// ALU opcode encoding (0 is reserved for "no issue").
package alu_rs_scheduler_pkg;

  localparam int ROB_ADDR_W      = 4;
  localparam int RS_SIZE_DEFAULT = 8;
  localparam int ALU_OP_W        = 6;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_IDLE = 6'd0,
    OP_ADD  = 6'd1,
    OP_SUB  = 6'd2,
    OP_AND  = 6'd3,
    OP_OR   = 6'd4,
    OP_XOR  = 6'd5,
    OP_SLL  = 6'd6,
    OP_SRL  = 6'd7,
    OP_SRA  = 6'd8,
    OP_SLT  = 6'd9,
    OP_SLTU = 6'd10
  } alu_op_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_rs_scheduler_picker.sv
// Combinational priority picker over a request vector. Lowest index wins by default;
// with RS_AGE_PRIORITY_EN the largest age wins (lowest index breaks ties).
module alu_rs_scheduler_picker #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]            req_i,
`ifdef RS_AGE_PRIORITY_EN
  input  logic [N-1:0][IDX_W-1:0] age_i,
`endif
  output logic                    found_o,
  output logic [IDX_W-1:0]        idx_o
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
`ifdef RS_AGE_PRIORITY_EN
    logic [IDX_W-1:0] best_age;
    best_age = '0;
`endif
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
`ifdef RS_AGE_PRIORITY_EN
      if (req_i[i] && (!found || age_i[i] > best_age)) begin
        found    = 1'b1;
        idx      = IDX_W'(i);
        best_age = age_i[i];
      end
`else
      if (req_i[i] && !found) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
`endif
    end
    found_o = found;
    idx_o   = idx;
  end

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: holds dispatched ops until both operands are captured from
// the ALU/LSB broadcasts, then issues one ready entry per cycle. RS_AGE_PRIORITY_EN selects oldest-first.
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEFAULT,
  parameter int ROB_W   = ROB_ADDR_W,
  parameter int OP_W    = ALU_OP_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rob_clear,
  input  logic             dis_valid,
  input  logic [OP_W-1:0]  dis_op,
  input  logic [31:0]      dis_vj,
  input  logic [31:0]      dis_vk,
  input  logic             dis_qj_pend,
  input  logic             dis_qk_pend,
  input  logic [ROB_W-1:0] dis_qj,
  input  logic [ROB_W-1:0] dis_qk,
  input  logic [ROB_W-1:0] dis_robid,
  output logic             rs_full,
  input  logic             cdb_alu_valid,
  input  logic [ROB_W-1:0] cdb_alu_robid,
  input  logic [31:0]      cdb_alu_result,
  input  logic             cdb_lsb_valid,
  input  logic [ROB_W-1:0] cdb_lsb_robid,
  input  logic [31:0]      cdb_lsb_result,
  output logic [OP_W-1:0]  iss_op,
  output logic [31:0]      iss_rs1,
  output logic [31:0]      iss_rs2,
  output logic [ROB_W-1:0] iss_robid
);

  localparam int IDX_W = idx_width(RS_SIZE);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [ROB_W-1:0] qj;
    logic [ROB_W-1:0] qk;
    logic             qj_pend;
    logic             qk_pend;
    logic [ROB_W-1:0] robid;
  } entry_t;

  logic [RS_SIZE-1:0] busy_q, busy_d, ready;
  entry_t             ent_q [RS_SIZE];
  entry_t             ent_d [RS_SIZE];
  entry_t             dis_ent;

  logic [OP_W-1:0]  iss_op_q, iss_op_d;
  logic [31:0]      iss_rs1_q, iss_rs1_d, iss_rs2_q, iss_rs2_d;
  logic [ROB_W-1:0] iss_robid_q, iss_robid_d;

  logic             free_found, iss_found, dis_fire, iss_fire;
  logic [IDX_W-1:0] free_idx, iss_idx;

  // Returns {pend, value}; the ALU port wins when both ports carry the awaited tag.
  function automatic logic [32:0] capture(input logic pend, input logic [ROB_W-1:0] tag,
                                          input logic [31:0] val);
    if (pend && cdb_alu_valid && cdb_alu_robid == tag) return {1'b0, cdb_alu_result};
    if (pend && cdb_lsb_valid && cdb_lsb_robid == tag) return {1'b0, cdb_lsb_result};
    return {pend, val};
  endfunction

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++)
      ready[i] = busy_q[i] && !ent_q[i].qj_pend && !ent_q[i].qk_pend;
  end

  assign rs_full  = &busy_q;
  assign dis_fire = dis_valid && free_found && !rs_full && rdy_in && !rob_clear;
  assign iss_fire = iss_found && rdy_in && !rob_clear;

`ifdef RS_AGE_PRIORITY_EN
  // Age = number of busy entries dispatched after this one, so the oldest has the largest age.
  logic [RS_SIZE-1:0][IDX_W-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (rdy_in && !rob_clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && !(iss_fire && iss_idx == IDX_W'(i))) begin
          if (iss_fire && age_q[i] > age_q[iss_idx]) age_d[i] = age_d[i] - 1'b1;
          if (dis_fire) age_d[i] = age_d[i] + 1'b1;
        end
      end
      if (dis_fire) age_d[free_idx] = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) age_q <= '0;
    else         age_q <= age_d;
  end
`endif

  alu_rs_scheduler_picker #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_pick (
    .req_i   (~busy_q),
`ifdef RS_AGE_PRIORITY_EN
    .age_i   ('0),
`endif
    .found_o (free_found),
    .idx_o   (free_idx)
  );

  alu_rs_scheduler_picker #(.N(RS_SIZE), .IDX_W(IDX_W)) u_iss_pick (
    .req_i   (ready),
`ifdef RS_AGE_PRIORITY_EN
    .age_i   (age_q),
`endif
    .found_o (iss_found),
    .idx_o   (iss_idx)
  );

  always_comb begin
    dis_ent.op    = dis_op;
    dis_ent.qj    = dis_qj;
    dis_ent.qk    = dis_qk;
    dis_ent.robid = dis_robid;
    {dis_ent.qj_pend, dis_ent.vj} = capture(dis_qj_pend, dis_qj, dis_vj);
    {dis_ent.qk_pend, dis_ent.vk} = capture(dis_qk_pend, dis_qk, dis_vk);
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path through the block infers a latch.
    busy_d      = busy_q;
    ent_d       = ent_q;
    iss_op_d    = '0;
    iss_rs1_d   = iss_rs1_q;
    iss_rs2_d   = iss_rs2_q;
    iss_robid_d = iss_robid_q;
    if (rdy_in) begin
      if (rob_clear) begin
        busy_d = '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i]) begin
            {ent_d[i].qj_pend, ent_d[i].vj} = capture(ent_q[i].qj_pend, ent_q[i].qj, ent_q[i].vj);
            {ent_d[i].qk_pend, ent_d[i].vk} = capture(ent_q[i].qk_pend, ent_q[i].qk, ent_q[i].vk);
          end
        end
        if (iss_fire) begin
          busy_d[iss_idx] = 1'b0;
          iss_op_d        = ent_q[iss_idx].op;
          iss_rs1_d       = ent_q[iss_idx].vj;
          iss_rs2_d       = ent_q[iss_idx].vk;
          iss_robid_d     = ent_q[iss_idx].robid;
        end
        if (dis_fire) begin
          busy_d[free_idx] = 1'b1;
          ent_d[free_idx]  = dis_ent;
        end
      end
    end
  end

  // NOTE: state registers update only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q      <= '0;
      iss_op_q    <= '0;
      iss_rs1_q   <= '0;
      iss_rs2_q   <= '0;
      iss_robid_q <= '0;
    end else begin
      busy_q      <= busy_d;
      iss_op_q    <= iss_op_d;
      iss_rs1_q   <= iss_rs1_d;
      iss_rs2_q   <= iss_rs2_d;
      iss_robid_q <= iss_robid_d;
    end
  end

  // NOTE: entry payload is left unreset; busy qualifies every field, so it behaves as plain storage.
  always_ff @(posedge clk_in) begin
    ent_q <= ent_d;
  end

  assign iss_op    = iss_op_q;
  assign iss_rs1   = iss_rs1_q;
  assign iss_rs2   = iss_rs2_q;
  assign iss_robid = iss_robid_q;

endmodule
